// File: rtl/commu_tx_arb_if.sv
// commu_tx_arb_if
//   Bundles the engine-side and tx-side word signals of the commu tx arbiter.
//   The arbiter connects through the master modport. The push engines and the
//   tx serializer (or a testbench) connect through the slave modport.
//   Signals:
//     req_frm   [N]     per-engine frame request/hold level
//     req_fire  [N]     per-engine 1-cycle word fire
//     req_data  [16*N]  per-engine word, engine i at [16*i+15:16*i]
//     req_done  [N]     per-engine 1-cycle word-complete pulse
//     grant     [N]     one-hot owner of the tx path, 0 = none
//     fire_tx           1-cycle fire to the tx path
//     data_tx   [16]    word to the tx path, 16'h0 when fire_tx is low
//     done_tx           1-cycle word-complete from the tx path
interface commu_tx_arb_if #(
  parameter int N = 2
) ();
  logic [N-1:0]    req_frm;
  logic [N-1:0]    req_fire;
  logic [16*N-1:0] req_data;
  logic [N-1:0]    req_done;
  logic [N-1:0]    grant;
  logic            fire_tx;
  logic [15:0]     data_tx;
  logic            done_tx;

  modport master (
    input  req_frm, req_fire, req_data, done_tx,
    output req_done, grant, fire_tx, data_tx
  );

  modport slave (
    output req_frm, req_fire, req_data, done_tx,
    input  req_done, grant, fire_tx, data_tx
  );
endinterface

// File: rtl/commu_tx_arb.sv
// commu_tx_arb
//   Shares the single commu tx word path among N push engines. An engine owns
//   the path for a whole frame, which lasts as long as its req_frm level is
//   held. Frames are granted round-robin. Each word fire is relayed to the tx
//   path, and the word completion is relayed back. A watchdog forces the word
//   to complete if done_tx never arrives.
//   Ports:
//     clk_sys    system clock
//     rst        synchronous reset, active-high
//     bus        commu_tx_arb_if master view (engine and tx word signals)
//     err_tmo    1-cycle pulse: the watchdog expired
//     err_drop   1-cycle pulse: one or more req_fire were ignored
//     dbg_state  current FSM state (S_IDLE=0, S_HOLD=1, S_WAIT=2, S_REL=3)
//
// Handshake: there is no ready signal. req_fire/fire_tx are 1-cycle "valid"
// strobes, accepted only from the owner while no word is outstanding. A fire
// from anyone else is dropped and reported. done_tx/req_done close the single
// outstanding word. All outputs are registered, so they appear one cycle after
// the input that causes them.
module commu_tx_arb #(
  parameter int          N       = 2,
  parameter logic [15:0] TMO_CYC = 16'd4096
) (
  input  logic            clk_sys,
  input  logic            rst,
  commu_tx_arb_if.master  bus,
  output logic            err_tmo,
  output logic            err_drop,
  output logic [1:0]      dbg_state
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_WAIT = 2'd2,
    S_REL  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, own_q, own_d;
  logic [PW-1:0]   pick, own_inc;
  logic [PW:0]     pick_idx, own_sum;
  logic            pick_found;
  logic [15:0]     cnt_q, cnt_d, word;
  logic [N-1:0]    grant_q, grant_d, done_q, done_d;
  logic [N-1:0]    own_oh, pick_oh, accept;
  logic            fire_q, fire_d, tmo_q, tmo_d, drop_q, drop_d;
  logic [15:0]     data_q, data_d;
  logic            any_req, fire_own, frm_own, tmo_hit;

  // Round-robin pick: first requesting engine at or after ptr, wrapping mod N.
  always_comb begin
    pick       = ptr_q;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < N; k++) begin
      pick_idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (pick_idx >= (PW+1)'(N)) pick_idx = pick_idx - (PW+1)'(N);
      if (!pick_found && bus.req_frm[pick_idx[PW-1:0]]) begin
        pick       = pick_idx[PW-1:0];
        pick_found = 1'b1;
      end
    end
  end

  // Engine after the current owner, mod N; becomes the next search start.
  always_comb begin
    own_sum = {1'b0, own_q} + (PW+1)'(1);
    own_inc = (own_sum >= (PW+1)'(N)) ? '0 : own_sum[PW-1:0];
  end

  // Word of the current owner.
  always_comb begin
    word = 16'h0;
    for (int i = 0; i < N; i++) begin
      if (own_q == PW'(i)) word = bus.req_data[16*i +: 16];
    end
  end

  assign own_oh   = N'(1) << own_q;
  assign pick_oh  = N'(1) << pick;
  assign any_req  = |bus.req_frm;
  assign fire_own = |(bus.req_fire & own_oh);
  assign frm_own  = |(bus.req_frm & own_oh);
  // The counter is cleared on entry to S_WAIT and increments on every S_WAIT
  // edge. The edge at which it would reach TMO_CYC is therefore the timeout edge.
  assign tmo_hit  = (TMO_CYC != 16'd0) && (cnt_q >= TMO_CYC - 16'd1);
  // Only the owner in S_HOLD may fire. Every other fire is a drop.
  assign accept   = (state_q == S_HOLD) ? own_oh : '0;

  // State register, including the registered outputs.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      cnt_q   <= 16'h0;
      grant_q <= '0;
      done_q  <= '0;
      fire_q  <= 1'b0;
      data_q  <= 16'h0;
      tmo_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      fire_q  <= fire_d;
      data_q  <= data_d;
      tmo_q   <= tmo_d;
      drop_q  <= drop_d;
    end
  end

  // Next state, with the owner, pointer and watchdog bookkeeping.
  always_comb begin
    state_d = state_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (any_req) begin
          state_d = S_HOLD;
          own_d   = pick;
        end
      end
      S_HOLD: begin
        // A fire in the same cycle as a falling req_frm wins. The release is
        // re-evaluated after that word completes.
        if (fire_own) begin
          state_d = S_WAIT;
          cnt_d   = 16'h0;
        end else if (!frm_own) begin
          state_d = S_REL;
        end
      end
      S_WAIT: begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        if (bus.done_tx || tmo_hit) state_d = S_HOLD;
      end
      S_REL: begin
        state_d = S_IDLE;
        ptr_d   = own_inc;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output values registered at the next edge.
  always_comb begin
    grant_d = grant_q;
    done_d  = '0;
    fire_d  = 1'b0;
    data_d  = 16'h0;
    tmo_d   = 1'b0;
    drop_d  = |(bus.req_fire & ~accept);
    unique case (state_q)
      S_IDLE: if (any_req) grant_d = pick_oh;
      S_HOLD: begin
        if (fire_own) begin
          fire_d = 1'b1;
          data_d = word;
        end
      end
      S_WAIT: begin
        // done_tx takes priority over a coincident timeout.
        if (bus.done_tx) begin
          done_d = own_oh;
        end else if (tmo_hit) begin
          done_d = own_oh;
          tmo_d  = 1'b1;
        end
      end
      S_REL:   grant_d = '0;
      default: grant_d = '0;
    endcase
  end

  assign bus.grant    = grant_q;
  assign bus.req_done = done_q;
  assign bus.fire_tx  = fire_q;
  assign bus.data_tx  = data_q;
  assign err_tmo      = tmo_q;
  assign err_drop     = drop_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_commu_tx_arb.sv
// tb_commu_tx_arb
//   Testbench for commu_tx_arb with N=2 and TMO_CYC=8. Directed scenarios run
//   first, followed by randomized traffic. Every output is compared on every
//   cycle against a frame/word-level reference model.
module tb_commu_tx_arb;
  localparam int          N   = 2;
  localparam logic [15:0] TMO = 16'd8;

  // ---------------- clock / reset ----------------
  logic clk_sys = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_sys = ~clk_sys;

  commu_tx_arb_if #(.N(N)) bus ();
  logic       err_tmo, err_drop;
  logic [1:0] dbg_state;

  commu_tx_arb #(.N(N), .TMO_CYC(TMO)) dut (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .bus       (bus),
    .err_tmo   (err_tmo),
    .err_drop  (err_drop),
    .dbg_state (dbg_state)
  );

  // ---------------- counters / scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];
  logic [15:0] act_q[$];
  bit log_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- tx path responder ----------------
  // resp_mode: 0 = no responder (done driven by hand), 1 = fixed delay, 2 = random delay
  int   resp_mode = 0;
  int   resp_dly  = 4;
  int   resp_pend = 0;
  logic resp_done = 1'b0;
  logic man_done  = 1'b0;
  assign bus.done_tx = resp_done | man_done;

  always @(negedge clk_sys) begin
    resp_done = 1'b0;
    if (resp_pend > 0) begin
      resp_pend--;
      if (resp_pend == 0) resp_done = 1'b1;
    end
    if (resp_mode != 0 && bus.fire_tx === 1'b1)
      resp_pend = (resp_mode == 1) ? resp_dly : int'($urandom_range(1, 12));
    if (rst) resp_pend = 0;
  end

  // ---------------- reference model ----------------
  int           m_owner = -1;  // engine owning the frame, -1 when none
  int           m_ptr   = 0;   // engine searched first at the next arbitration
  int           m_wait  = 0;   // edges the outstanding word has waited
  bit           m_busy  = 1'b0;
  bit           m_rel   = 1'b0;
  bit           m_valid = 1'b0;
  logic [N-1:0] m_acc;
  logic [N-1:0] e_grant = '0, e_done = '0;
  logic         e_fire = 1'b0, e_tmo = 1'b0, e_drop = 1'b0;
  logic [15:0]  e_data = 16'h0;

  always @(posedge clk_sys) begin
    if (rst) begin
      m_owner = -1; m_ptr = 0; m_wait = 0; m_busy = 1'b0; m_rel = 1'b0;
      e_grant = '0; e_done = '0; e_fire = 1'b0; e_data = 16'h0;
      e_tmo = 1'b0; e_drop = 1'b0; m_valid = 1'b1;
    end else if (m_valid) begin
      m_acc = '0;
      if (m_owner >= 0 && !m_busy && !m_rel) m_acc[m_owner] = 1'b1;
      e_drop = |(bus.req_fire & ~m_acc);
      e_done = '0; e_fire = 1'b0; e_data = 16'h0; e_tmo = 1'b0;
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++)
          if (m_owner < 0 && bus.req_frm[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
        if (m_owner >= 0) begin
          e_grant = '0;
          e_grant[m_owner] = 1'b1;
        end
      end else if (m_rel) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
        m_rel   = 1'b0;
        e_grant = '0;
      end else if (m_busy) begin
        m_wait++;
        if (bus.done_tx) begin
          e_done[m_owner] = 1'b1;
          m_busy = 1'b0;
        end else if (TMO != 16'd0 && m_wait >= int'(TMO)) begin
          e_done[m_owner] = 1'b1;
          e_tmo  = 1'b1;
          m_busy = 1'b0;
        end
      end else if (bus.req_fire[m_owner]) begin
        e_fire = 1'b1;
        e_data = bus.req_data[16*m_owner +: 16];
        m_busy = 1'b1;
        m_wait = 0;
      end else if (!bus.req_frm[m_owner]) begin
        m_rel = 1'b1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_sys) begin
    if (m_valid) begin
      check("grant",    bus.grant,    e_grant);
      check("req_done", bus.req_done, e_done);
      check("fire_tx",  bus.fire_tx,  e_fire);
      check("data_tx",  bus.data_tx,  e_data);
      check("err_tmo",  err_tmo,      e_tmo);
      check("err_drop", err_drop,     e_drop);
      if (log_en && bus.fire_tx === 1'b1) act_q.push_back(bus.data_tx);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk_sys);
  endtask

  task automatic fire(input int e, input logic [15:0] w);
    bus.req_data[16*e +: 16] = w;
    bus.req_fire[e] = 1'b1;
    step();
    bus.req_fire[e] = 1'b0;
  endtask

  task automatic wait_grant(input logic [N-1:0] g, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 30 && !hit; i++) begin
      step();
      if (bus.grant === g) hit = 1'b1;
    end
    check(nm, bus.grant, g);
  endtask

  task automatic wait_done(input int e, input string nm);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      step();
      if (bus.req_done[e] === 1'b1) hit = 1'b1;
    end
    check(nm, hit, 1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c;
    bit hit;
    bus.req_frm  = '0;
    bus.req_fire = '0;
    bus.req_data = '0;
    rst = 1'b1;
    step();
    // Reset state
    check("rst_grant", bus.grant, 0);
    check("rst_fire",  bus.fire_tx, 0);
    check("rst_data",  bus.data_tx, 0);
    check("rst_done",  bus.req_done, 0);
    check("rst_state", dbg_state, 0);
    step();
    rst = 1'b0;
    step();

    // T1: engine0 frame with three words, done 4 cycles after each fire
    resp_mode = 1; resp_dly = 4; log_en = 1'b1;
    exp_q = {16'hA5A5, 16'h0001, 16'hFFFF};
    bus.req_frm[0] = 1'b1;
    step();
    check("t1_grant", bus.grant, 2'b01);
    c = 0;
    foreach (exp_q[i]) begin
      fire(0, exp_q[i]);
      wait_done(0, "t1_word_done");
      c++;
    end
    log_en = 1'b0;
    check("t1_fire_cnt", act_q.size(), 3);
    for (int i = 0; i < 3; i++) check("t1_word", (i < act_q.size()) ? act_q[i] : 16'hx, exp_q[i]);
    bus.req_frm[0] = 1'b0;
    step();
    check("t1_rel_hold", bus.grant, 2'b01);
    step();
    check("t1_rel_grant", bus.grant, 2'b00);
    step();

    // T2: simultaneous requests right after reset, round-robin order
    pulse_rst();
    bus.req_frm = 2'b11;
    step();
    check("t2_first", bus.grant, 2'b01);
    bus.req_frm = 2'b10;
    step();
    step();
    check("t2_gap", bus.grant, 2'b00);
    step();
    check("t2_follow", bus.grant, 2'b10);
    bus.req_frm = 2'b01;
    step();
    step();
    check("t2_gap2", bus.grant, 2'b00);
    step();
    check("t2_back", bus.grant, 2'b01);
    bus.req_frm = 2'b00;
    step();
    step();
    step();
    bus.req_frm = 2'b11;
    step();
    check("t2_repeat", bus.grant, 2'b10);
    bus.req_frm = 2'b00;
    repeat (3) step();

    // T3: fire from a non-owner is dropped
    bus.req_frm = 2'b01;
    wait_grant(2'b01, "t3_grant");
    fire(1, 16'h1111);
    check("t3_drop", err_drop, 1);
    check("t3_no_fire", bus.fire_tx, 0);
    step();
    check("t3_drop_once", err_drop, 0);

    // T4: watchdog timeout, then done_tx on the timeout cycle
    resp_mode = 0;
    fire(0, 16'h1234);
    check("t4_fire", bus.fire_tx, 1);
    c = 0; hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      c++;
      if (err_tmo === 1'b1) hit = 1'b1;
    end
    check("t4_tmo_lat", c, 8);
    check("t4_tmo_done", bus.req_done, 2'b01);
    fire(0, 16'h5678);
    repeat (7) step();
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    check("t4_done_wins", bus.req_done, 2'b01);
    check("t4_no_tmo", err_tmo, 0);
    step();

    // T5: reset while a word is outstanding; later done_tx is ignored
    fire(0, 16'h0BAD);
    step();
    bus.req_frm = 2'b00;
    pulse_rst();
    check("t5_grant", bus.grant, 0);
    check("t5_done",  bus.req_done, 0);
    check("t5_fire",  bus.fire_tx, 0);
    check("t5_data",  bus.data_tx, 0);
    check("t5_tmo",   err_tmo, 0);
    check("t5_state", dbg_state, 0);
    man_done = 1'b1;
    step();
    man_done = 1'b0;
    check("t5_late_done", bus.req_done, 0);
    step();
    check("t5_late_done2", bus.req_done, 0);

    // T6: fire coincides with the req_frm drop
    resp_mode = 1; resp_dly = 3;
    bus.req_frm = 2'b01;
    wait_grant(2'b01, "t6_grant");
    bus.req_frm[0] = 1'b0;
    fire(0, 16'hC3C3);
    check("t6_fire", bus.fire_tx, 1);
    check("t6_data", bus.data_tx, 16'hC3C3);
    wait_done(0, "t6_done");
    step();
    check("t6_rel_hold", bus.grant, 2'b01);
    step();
    check("t6_rel", bus.grant, 2'b00);
    step();

    // Randomized traffic
    resp_mode = 2;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int e = 0; e < N; e++) begin
        if ($urandom_range(0, 9) == 0) bus.req_frm[e] = ~bus.req_frm[e];
        bus.req_fire[e] = ($urandom_range(0, 4) == 0);
        bus.req_data[16*e +: 16] = 16'($urandom);
      end
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    bus.req_frm = '0; bus.req_fire = '0; rst = 1'b0;
    repeat (30) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL sim_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
